// File: rtl/sram_arbiter.sv
// N-port arbiter/controller for a 16-bit async SRAM: ack is combinational in the accept window, one access per ACCESS_CYCLES.
// Clients hold req until ack; read data returns with rvalid ACCESS_CYCLES+1 cycles after the read's ack.
module sram_arbiter #(
   parameter int NUM_PORTS     = 4,
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 2,
   parameter int RR_MODE       = 1
) (
   input  logic                          clock_100,
   input  logic                          reset_n,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   input  logic [NUM_PORTS*2-1:0]        be,
   output logic [NUM_PORTS-1:0]          ack,
   output logic [NUM_PORTS-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic                          busy,
   output logic                          CE,
   output logic                          OE,
   output logic                          WE,
   output logic                          UB,
   output logic                          LB,
   output logic [ADDR_W-1:0]             ADDR,
   inout  wire  [DATA_W-1:0]             Data
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(ACCESS_CYCLES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       ptr;
   logic [PW-1:0]       port_q;
   logic                wr_q;
   logic [1:0]          be_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                data_oe;

   logic                last_cyc;
   logic                accept;
   logic                take;
   logic                gnt_any;
   logic                hi_vld;
   logic [PW-1:0]       idx_lo;
   logic [PW-1:0]       idx_hi;
   logic [PW-1:0]       gnt_idx;
   logic [PW-1:0]       ptr_nxt;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_wdata;
   logic [1:0]          g_be;
   logic                g_we;
   logic [DATA_W-1:0]   byte_mask;

   assign last_cyc = (state == ACCESS) && (cnt == CW'(ACCESS_CYCLES - 1));
   assign accept   = (state == IDLE) || last_cyc;
   assign take     = accept && gnt_any;

   // Lowest requester overall, and lowest requester at or above the pointer;
   // the latter wins under round-robin, which gives the wrap-around search.
   always_comb begin
      gnt_any = 1'b0;
      hi_vld  = 1'b0;
      idx_lo  = '0;
      idx_hi  = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_any = 1'b1;
            idx_lo  = PW'(i);
            if (PW'(i) >= ptr) begin
               hi_vld = 1'b1;
               idx_hi = PW'(i);
            end
         end
      end
      gnt_idx = (RR_MODE != 0 && hi_vld) ? idx_hi : idx_lo;
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         ack[i] = take && (gnt_idx == PW'(i));
      end
   end

   assign ptr_nxt   = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
   assign g_addr    = addr[gnt_idx*ADDR_W +: ADDR_W];
   assign g_wdata   = wdata[gnt_idx*DATA_W +: DATA_W];
   assign g_be      = be[gnt_idx*2 +: 2];
   assign g_we      = we[gnt_idx];
   assign byte_mask = {{8{be_q[1]}}, {8{be_q[0]}}};

   assign Data = data_oe ? wdata_q : {DATA_W{1'bz}};

   always_ff @(posedge clock_100 or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= '0;
         port_q  <= '0;
         wr_q    <= 1'b0;
         be_q    <= 2'b00;
         wdata_q <= '0;
         data_oe <= 1'b0;
         CE      <= 1'b1;
         OE      <= 1'b1;
         WE      <= 1'b1;
         UB      <= 1'b1;
         LB      <= 1'b1;
         ADDR    <= '0;
         busy    <= 1'b0;
         rvalid  <= '0;
         rdata   <= '0;
      end else begin
         rvalid <= '0;
         // Read data is taken at the edge closing the access; the next access may start on the same edge.
         if (last_cyc && !wr_q) begin
            rdata          <= Data & byte_mask;
            rvalid[port_q] <= 1'b1;
         end

         if (take) begin
            state   <= ACCESS;
            cnt     <= '0;
            port_q  <= gnt_idx;
            wr_q    <= g_we;
            be_q    <= g_be;
            wdata_q <= g_wdata;
            if (RR_MODE != 0) begin
               ptr <= ptr_nxt;
            end
            data_oe <= g_we;
            CE      <= 1'b0;
            OE      <= g_we;
            WE      <= 1'b1;
            UB      <= ~g_be[1];
            LB      <= ~g_be[0];
            ADDR    <= g_addr;
            busy    <= 1'b1;
         end else if (state == ACCESS && !last_cyc) begin
            cnt <= cnt + 1'b1;
            // First cycle is address setup; the strobe covers the rest of a write.
            WE  <= ~(wr_q && (be_q != 2'b00));
         end else if (state == ACCESS) begin
            state   <= IDLE;
            cnt     <= '0;
            data_oe <= 1'b0;
            CE      <= 1'b1;
            OE      <= 1'b1;
            WE      <= 1'b1;
            UB      <= 1'b1;
            LB      <= 1'b1;
            busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Two arbiter instances (round-robin/2-cycle and fixed-priority/3-cycle), each with an SRAM model and scoreboard.
module tb_sram_arbiter;

   localparam int NP = 4;
   localparam int AW = 20;

   typedef struct {
      int          p;
      logic        w;
      logic [19:0] a;
      logic [15:0] d;
      logic [1:0]  b;
   } txn_t;

   typedef struct {
      logic [3:0]  oh;
      logic [15:0] d;
      int          due;
   } rexp_t;

   logic clock_100 = 1'b0;
   always #5 clock_100 = ~clock_100;

   int checks = 0;
   int errors = 0;
   bit done [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Power-up contents shared by the SRAM model and the reference memory
   function automatic logic [15:0] init_val(input logic [19:0] a);
      return a[15:0] ^ {a[19:16], 12'h5A3};
   endfunction

   function automatic txn_t mk(input int p, input logic w, input logic [19:0] a,
                               input logic [15:0] d, input logic [1:0] b);
      txn_t t;
      t.p = p; t.w = w; t.a = a; t.d = d; t.b = b;
      return t;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_inst
      localparam int RR = (k == 0) ? 1 : 0;
      localparam int AC = (k == 0) ? 2 : 3;

      logic             reset_n;
      logic [NP-1:0]    req, we, ack, rvalid;
      logic [NP*AW-1:0] addr;
      logic [NP*16-1:0] wdata;
      logic [NP*2-1:0]  be;
      logic [15:0]      rdata;
      logic             busy, CE, OE, WE, UB, LB;
      logic [AW-1:0]    ADDR;
      wire  [15:0]      Data;

      sram_arbiter #(
         .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(16), .ACCESS_CYCLES(AC), .RR_MODE(RR)
      ) dut (
         .clock_100(clock_100), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
         .wdata(wdata), .be(be), .ack(ack), .rvalid(rvalid), .rdata(rdata), .busy(busy),
         .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .ADDR(ADDR), .Data(Data)
      );

      // SRAM model: writes while CE/WE are low, drives the bus while reading
      logic [15:0] sram [logic [19:0]];
      logic [15:0] rd_val = 16'h0;
      assign Data = (!CE && !OE && WE) ? rd_val : 16'hzzzz;

      always @(negedge clock_100) begin
         logic [15:0] old;
         if (!CE && !WE) begin
            old = sram.exists(ADDR) ? sram[ADDR] : init_val(ADDR);
            sram[ADDR] = {UB ? old[15:8] : Data[15:8], LB ? old[7:0] : Data[7:0]};
         end
         rd_val = sram.exists(ADDR) ? sram[ADDR] : init_val(ADDR);
      end

      int cyc = 0;
      always @(posedge clock_100) cyc <= cyc + 1;

      // Reference model state
      bit          mon_on = 1'b0;
      bit          has_g  = 1'b0;
      int          tg     = 0;
      int          ptr    = 0;
      logic        cw;
      logic [19:0] ca;
      logic [15:0] cd;
      logic [1:0]  cb;
      logic [15:0] ref_mem [logic [19:0]];
      rexp_t       rq [$];

      function automatic logic [15:0] ref_rd(input logic [19:0] a);
         return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
      endfunction

      always @(negedge clock_100) begin
         if (mon_on) begin
            int          eg;
            int          o;
            bit          in_acc;
            logic [25:0] pin_exp;
            logic [15:0] m;
            logic [19:0] ga;
            logic [15:0] gd;
            logic [1:0]  gb;
            rexp_t       e;

            eg = -1;
            if ((!has_g || (cyc - tg >= AC)) && req != 0) begin
               for (int j = 0; j < NP; j++) begin
                  int p;
                  p = (RR != 0) ? (ptr + j) % NP : j;
                  if (eg < 0 && req[p]) eg = p;
               end
            end
            check($sformatf("i%0d ack cyc%0d", k, cyc), 64'(ack), (eg >= 0) ? (64'd1 << eg) : 64'd0);

            in_acc = has_g && (cyc >= tg + 1) && (cyc <= tg + AC);
            o = cyc - tg - 1;
            if (in_acc)
               pin_exp = {1'b0, cw, (cw && cb != 2'b00 && o >= 1) ? 1'b0 : 1'b1, ~cb[1], ~cb[0], 1'b1, ca};
            else
               pin_exp = {5'b11111, 1'b0, 20'h0};
            check($sformatf("i%0d pins cyc%0d", k, cyc),
                  64'({CE, OE, WE, UB, LB, busy, in_acc ? ADDR : 20'h0}), 64'(pin_exp));
            if (in_acc && cw)
               check($sformatf("i%0d wr bus cyc%0d", k, cyc), 64'(Data), 64'(cd));

            if (rvalid != 0 || (rq.size() > 0 && rq[0].due <= cyc)) begin
               if (rq.size() == 0) begin
                  check($sformatf("i%0d spurious rvalid cyc%0d", k, cyc), 64'(rvalid), 64'd0);
               end else begin
                  e = rq.pop_front();
                  check($sformatf("i%0d rvalid/rdata/cycle", k),
                        {12'h0, rvalid, rdata, 32'(cyc)}, {12'h0, e.oh, e.d, 32'(e.due)});
               end
            end

            if (eg >= 0) begin
               ga = addr[eg*AW +: AW];
               gd = wdata[eg*16 +: 16];
               gb = be[eg*2 +: 2];
               m  = {{8{gb[1]}}, {8{gb[0]}}};
               has_g = 1'b1;
               tg = cyc;
               cw = we[eg]; ca = ga; cd = gd; cb = gb;
               if (RR != 0) ptr = (eg + 1) % NP;
               if (we[eg]) begin
                  ref_mem[ga] = (ref_rd(ga) & ~m) | (gd & m);
               end else begin
                  e.oh = 4'(1 << eg); e.d = ref_rd(ga) & m; e.due = cyc + AC + 1;
                  rq.push_back(e);
               end
            end
         end
      end

      // Stimulus
      txn_t dq [$];
      int   rand_pct = 0;

      task automatic load(input txn_t t);
         req[t.p]            = 1'b1;
         we[t.p]             = t.w;
         addr[t.p*AW +: AW]  = t.a;
         wdata[t.p*16 +: 16] = t.d;
         be[t.p*2 +: 2]      = t.b;
      endtask

      function automatic txn_t rand_txn(input int p);
         int r;
         logic [19:0] a;
         r = $urandom_range(0, 19);
         case (r)
            16:      a = 20'h00012;
            17:      a = 20'h00040;
            18:      a = 20'h7FFFF;
            19:      a = 20'hFFFFF;
            default: a = 20'(r);
         endcase
         return mk(p, 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)));
      endfunction

      task automatic step();
         logic [NP-1:0] acked;
         @(negedge clock_100);
         acked = ack;
         @(posedge clock_100);
         #1;
         for (int p = 0; p < NP; p++) if (acked[p]) req[p] = 1'b0;
         while (dq.size() > 0 && !req[dq[0].p]) begin
            load(dq[0]);
            void'(dq.pop_front());
         end
         for (int p = 0; p < NP; p++)
            if (!req[p] && $urandom_range(0, 99) < rand_pct) load(rand_txn(p));
      endtask

      initial begin
         int n;
         reset_n = 1'b0;
         req = '0; we = '0; addr = '0; wdata = '0; be = '0;
         repeat (3) @(posedge clock_100);
         @(negedge clock_100);
         check($sformatf("i%0d reset state", k),
               64'({ack, rvalid, rdata, busy, CE, OE, WE, UB, LB, ADDR}),
               64'({4'h0, 4'h0, 16'h0, 1'b0, 5'b11111, 20'h0}));
         @(posedge clock_100); #1 reset_n = 1'b1;

         // Write from port 2 (moves the pointer), then reset during its strobe
         @(posedge clock_100); #1 load(mk(2, 1'b1, 20'h55555, 16'h0F0F, 2'b11));
         @(negedge clock_100);
         check($sformatf("i%0d first ack", k), 64'(ack), 64'h4);
         @(posedge clock_100); #1 req = '0;
         @(posedge clock_100); #1;
         check($sformatf("i%0d write strobe", k), 64'({CE, WE}), 64'h0);
         reset_n = 1'b0;
         #1;
         check($sformatf("i%0d async reset pins", k), 64'({CE, OE, WE, busy}), 64'b1110);
         repeat (2) begin
            @(negedge clock_100);
            check($sformatf("i%0d rvalid in reset", k), 64'(rvalid), 64'h0);
         end
         @(posedge clock_100); #1 reset_n = 1'b1;
         mon_on = 1'b1;

         dq.push_back(mk(1, 1'b0, 20'h00003, 16'h0, 2'b11));
         dq.push_back(mk(3, 1'b0, 20'h00005, 16'h0, 2'b11));
         dq.push_back(mk(0, 1'b1, 20'h00012, 16'hBEEF, 2'b11));
         dq.push_back(mk(0, 1'b0, 20'h00012, 16'h0, 2'b11));
         dq.push_back(mk(0, 1'b1, 20'h00040, 16'hFFFF, 2'b11));
         dq.push_back(mk(0, 1'b1, 20'h00040, 16'h1234, 2'b10));
         dq.push_back(mk(0, 1'b0, 20'h00040, 16'h0, 2'b11));
         dq.push_back(mk(0, 1'b0, 20'h7FFFF, 16'h0, 2'b11));
         dq.push_back(mk(0, 1'b1, 20'h00007, 16'hAAAA, 2'b00));
         dq.push_back(mk(0, 1'b0, 20'h00007, 16'h0, 2'b00));
         dq.push_back(mk(0, 1'b0, 20'h00007, 16'h0, 2'b01));

         n = 0;
         while (n < 300 && !(dq.size() == 0 && req == 0 && rq.size() == 0)) begin step(); n++; end
         check($sformatf("i%0d directed drain", k), 64'(dq.size() == 0 && req == 0 && rq.size() == 0), 64'd1);

         rand_pct = 100;
         repeat (120) step();
         rand_pct = 30;
         repeat (1500) step();
         rand_pct = 0;
         n = 0;
         while (n < 300 && !(req == 0 && rq.size() == 0)) begin step(); n++; end
         check($sformatf("i%0d final drain", k), 64'(req == 0 && rq.size() == 0), 64'd1);
         repeat (AC + 2) step();
         done[k] = 1'b1;
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(done[0] && done[1]) && t < 20000) begin
         @(posedge clock_100);
         t++;
      end
      if (!(done[0] && done[1])) begin
         checks++;
         errors++;
         $display("FAIL timeout: done flags %0d%0d, expected 11", done[0], done[1]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
